registrador_ctrl: RTL and testbench
===================================

# registrador_ctrl

Sequencer and two-port round-robin arbiter for the 8-bit serial-in/parallel-out shift register `registrador`. Two requesters each offer a WIDTH-bit word over a valid/ready handshake. The controller grants one requester and serializes its word MSB-first into the register by driving the register's A/B inputs for WIDTH clocks. It then compares the register's parallel outputs against the word and pulses `done` with a `match` flag. It shares CLOCK and CLEAR with the register it drives.

## Interface
- WIDTH, 8: bits per transfer; must equal the attached register length.
- CLOCK  in  1  rising-edge clock, shared with the register.
- CLEAR  in  1  asynchronous, active-low reset, shared with the register.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  WIDTH  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid, req1_data, req1_ready: same as requester 0, for requester 1.
- A  out  1  register serial input A.
- B  out  1  register serial input B.
- q_in  in  WIDTH  register parallel outputs, {QH,QG,…,QA}; QH is the MSB.
- busy  out  1  transfer in progress (state ≠ IDLE).
- done  out  1  one-cycle pulse at end of transfer.
- match  out  1  valid only while done=1; q_in equals the latched word.
- grant_id  out  1  requester owning the current/last transfer.

## Operation
- Register encoding driven by A/B:
  - A=B=1: shift in 1.
  - A=1, B=0: shift in 0.
  - A=B=0: hold.
- States: IDLE, SHIFT, CHECK.
- **IDLE**
  - Outputs: A=B=0, busy=0.
  - Arbitration: grant0 = req0_valid & (!req1_valid | last==1); grant1 = req1_valid & (!req0_valid | last==0).
  - reqN_ready = IDLE & grantN, combinational.
  - A handshake completes when valid & ready.
  - On handshake: latch data into shreg and data_lat; set grant_id and last to N; clear cnt; go to SHIFT.
- **SHIFT**
  - Outputs: A=1, B=shreg[WIDTH-1], busy=1.
  - Each edge: shreg <<= 1, cnt++.
  - At the edge where cnt==WIDTH-1: go to CHECK.
- **CHECK**
  - Outputs: A=B=0, busy=1, done=1, match = (q_in == data_lat).
  - Next edge: go to IDLE.
- cnt is $clog2(WIDTH) bits and never wraps in normal operation.
- Requesters must hold valid and data stable until ready. No acceptance occurs outside IDLE.
- Round-robin applies only on simultaneous valids; a lone valid is always granted.

## Timing
- Reset (CLEAR low, asynchronous):
  - state=IDLE, shreg=0, data_lat=0, cnt=0, grant_id=0, last=1 (req0 wins the first tie).
  - A=B=0, busy=0, done=0, match=0.
  - req0_ready=req1_ready=0: forced low while CLEAR=0.
- Latency:
  - Handshake at edge e0.
  - SHIFT occupies cycles 1..WIDTH; the register shifts at edges e1..eWIDTH.
  - done is high in cycle WIDTH+1.
  - Earliest next handshake is in cycle WIDTH+2.
  - Accept-to-accept period is therefore ≥ WIDTH+2 cycles.
- A/B and done/match decode from registered state, so they are glitch-free at the register edge.
- CLEAR mid-transfer: immediate return to IDLE, no done pulse, transfer discarded. The register is cleared by the same CLEAR. The requester is not re-notified.
- Valid deasserted in the same cycle that ready rises: no handshake, stay in IDLE.
- done/match are 0 in every cycle except the single CHECK cycle.

## Test plan
- Reset:
  - Hold CLEAR=0 with both valids=1: all outputs 0.
  - Release CLEAR with valids=0 for 20 cycles: A=B=0, busy=0, register holds 0x00.
- Single transfer:
  - Drive req0 0xA5.
  - ready0=1 in the handshake cycle.
  - Over 8 cycles A=1 and B = 1,0,1,0,0,1,0,1.
  - done=1 and match=1 in cycle 9; grant_id=0; q_in=0xA5.
- Arbitration:
  - Both valid from reset, req0=0x3C, req1=0xC3.
  - Order: req0 first, then req1, then req0 again if both remain valid.
  - Each transfer ends with match=1 and the correct q_in.
  - Accept spacing is exactly 10 cycles.
- Corners:
  - 0x00: B=0 for all 8 cycles, q_in=0x00.
  - 0xFF: B=1 for all 8 cycles, q_in=0xFF.
  - Both transfers end with match=1.
- Mismatch:
  - Bench overrides q_in to 0x00 during CHECK of a 0xFF transfer.
  - Required: done=1, match=0.
- Reset mid-transfer:
  - Pulse CLEAR low in SHIFT cycle 4.
  - Required: busy=0, A=B=0, no done, register cleared.
  - Next req1 0x5A then completes with match=1.

Source files
------------

// File: rtl/registrador_ctrl.sv
// registrador_ctrl: two-port round-robin arbiter that serializes the granted word
// MSB-first into the 'registrador' shift register and checks the parallel read-back.
module registrador_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK,
    input  logic             CLEAR,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             A,
    output logic             B,
    input  logic [WIDTH-1:0] q_in,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic             grant_id,
    output logic [1:0]       state_dbg
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] data_lat;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             grant0;
    logic             grant1;
    logic             hs0;
    logic             hs1;

    // Handshake: a word is accepted at a rising edge where valid and ready are both
    // high; ready is offered only in IDLE, only to the granted port, never under CLEAR.
    assign grant0 = req0_valid & (~req1_valid | last);
    assign grant1 = req1_valid & (~req0_valid | ~last);
    assign hs0    = req0_valid & req0_ready;
    assign hs1    = req1_valid & req1_ready;

    always_ff @(posedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs0 | hs1) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cnt holds at its last value on the final shift edge so it never wraps.
    always_ff @(posedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            shreg    <= '0;
            data_lat <= '0;
            cnt      <= '0;
            grant_id <= 1'b0;
            last     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (hs0) begin
                        shreg    <= req0_data;
                        data_lat <= req0_data;
                        grant_id <= 1'b0;
                        last     <= 1'b0;
                        cnt      <= '0;
                    end else if (hs1) begin
                        shreg    <= req1_data;
                        data_lat <= req1_data;
                        grant_id <= 1'b1;
                        last     <= 1'b1;
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        A          = 1'b0;
        B          = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        match      = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0 & CLEAR;
                req1_ready = grant1 & CLEAR;
            end
            SHIFT: begin
                A    = 1'b1;
                B    = shreg[WIDTH-1];
                busy = 1'b1;
            end
            CHECK: begin
                busy  = 1'b1;
                done  = 1'b1;
                match = (q_in == data_lat);
            end
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_registrador_ctrl.sv
// Bench for registrador_ctrl: behavioural shift register on A/B, directed and
// randomized transfers checked against a round-robin / MSB-first reference model.
module tb_registrador_ctrl;
    localparam int W = 8;

    logic         CLOCK = 1'b0;
    logic         CLEAR = 1'b0;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_data = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_data = '0;
    logic         req1_ready;
    logic         A;
    logic         B;
    logic [W-1:0] q_in;
    logic         busy;
    logic         done;
    logic         match;
    logic         grant_id;
    logic [1:0]   state_dbg;

    logic [W-1:0] reg_q;
    logic         ovr_en = 1'b0;
    logic [W-1:0] ovr_val = '0;
    logic [W-1:0] exp_q[$];
    logic         last_m = 1'b1;
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           done_cnt = 0;
    int           t_acc = 0;
    int           t0;
    int           dc0;

    registrador_ctrl #(.WIDTH(W)) dut (
        .CLOCK      (CLOCK),
        .CLEAR      (CLEAR),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .A          (A),
        .B          (B),
        .q_in       (q_in),
        .busy       (busy),
        .done       (done),
        .match      (match),
        .grant_id   (grant_id),
        .state_dbg  (state_dbg)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc++;
    always @(negedge CLOCK) if (done) done_cnt++;

    // Shift register model: serial input enters at QA, QH is the MSB.
    always @(posedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) reg_q <= '0;
        else if (A) reg_q <= {reg_q[W-2:0], B};
    end
    assign q_in = ovr_en ? ovr_val : reg_q;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before 300us");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Offers the given valids/words, then follows one whole transfer of the winner.
    // Entered and left 1 time unit after a rising edge.
    task automatic serve(input logic v0, input logic v1, input logic [W-1:0] d0,
                         input logic [W-1:0] d1, input logic keep, input logic ovr,
                         input logic [W-1:0] ov);
        logic         win;
        logic [W-1:0] w;
        logic [W-1:0] exp_word;
        logic         got;
        req0_valid = v0;
        req1_valid = v1;
        req0_data  = d0;
        req1_data  = d1;
        win = (v0 && v1) ? ~last_m : v1;
        w   = win ? d1 : d0;
        exp_q.push_back(w);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge CLOCK);
            if (req0_ready || req1_ready) got = 1'b1;
            else begin
                @(posedge CLOCK);
                #1;
            end
        end
        if (!got) begin
            check("accept_timeout", {31'b0, got}, 1);
            void'(exp_q.pop_front());
            return;
        end
        check("ready_win", win ? req1_ready : req0_ready, 1);
        check("ready_lose", win ? req0_ready : req1_ready, 0);
        @(posedge CLOCK);
        #1;
        t_acc = cyc;
        if (!keep) begin
            if (win) req1_valid = 1'b0;
            else req0_valid = 1'b0;
        end
        last_m = win;
        for (int i = 0; i < W; i++) begin
            @(negedge CLOCK);
            check("shift_A", A, 1);
            check("shift_B", B, w[W-1-i]);
            check("shift_busy", busy, 1);
            check("shift_done", done, 0);
            @(posedge CLOCK);
            #1;
        end
        ovr_en  = ovr;
        ovr_val = ov;
        @(negedge CLOCK);
        exp_word = exp_q.pop_front();
        check("done", done, 1);
        check("match", match, ovr ? (ov == exp_word) : 1'b1);
        check("grant_id", grant_id, win);
        check("reg_q", reg_q, exp_word);
        check("check_A", A, 0);
        @(posedge CLOCK);
        #1;
        ovr_en = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    initial begin
        // Reset held with both requesters valid
        CLEAR = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data = 8'($urandom);
        req1_data = 8'($urandom);
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_match", match, 0);
        check("rst_grant", grant_id, 0);
        check("rst_state", state_dbg, 0);
        @(posedge CLOCK);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        CLEAR = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLOCK);
            check("quiet_A", A, 0);
            check("quiet_B", B, 0);
            check("quiet_busy", busy, 0);
            check("quiet_reg", reg_q, 0);
            @(posedge CLOCK);
            #1;
        end

        // Single transfer
        serve(1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00);

        // Arbitration from a fresh reset: req0, req1, req0 with 10-cycle spacing
        CLEAR = 1'b0;
        #2;
        CLEAR = 1'b1;
        last_m = 1'b1;
        @(posedge CLOCK);
        #1;
        serve(1'b1, 1'b1, 8'h3C, 8'hC3, 1'b1, 1'b0, 8'h00);
        t0 = t_acc;
        serve(1'b1, 1'b1, 8'h3C, 8'hC3, 1'b1, 1'b0, 8'h00);
        check("spacing_01", t_acc - t0, 10);
        t0 = t_acc;
        serve(1'b1, 1'b1, 8'h3C, 8'hC3, 1'b1, 1'b0, 8'h00);
        check("spacing_12", t_acc - t0, 10);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Corner words
        serve(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        serve(1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00);

        // Read-back mismatch forced during CHECK
        serve(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00);

        // Randomized traffic
        for (int r = 0; r < 8; r++) begin
            logic rv0;
            logic rv1;
            rv0 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            if (!rv0 && !rv1) rv1 = 1'b1;
            serve(rv0, rv1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 8'h00);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLOCK);
                #1;
            end
        end

        // CLEAR pulsed in SHIFT cycle 4
        dc0 = done_cnt;
        req0_valid = 1'b1;
        req0_data = 8'h96;
        @(negedge CLOCK);
        check("mid_ready", req0_ready, 1);
        @(posedge CLOCK);
        #1;
        req0_valid = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        check("mid_busy_pre", busy, 1);
        CLEAR = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_A", A, 0);
        check("mid_B", B, 0);
        check("mid_reg", reg_q, 0);
        @(posedge CLOCK);
        #1;
        CLEAR = 1'b1;
        last_m = 1'b1;
        repeat (12) begin
            @(negedge CLOCK);
            check("post_clear_busy", busy, 0);
            @(posedge CLOCK);
            #1;
        end
        check("no_done", done_cnt, dc0);
        serve(1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
